slow_tick_counter: RTL
======================

Name: slow_tick_counter

Overview:
Consumes the divided square wave produced by the clock divider and works entirely in the fast ClkIn domain. Synchronises the slow clock and detects its rising edges as single-cycle Tick strobes. Drives a programmable modulo counter with wrap strobe, for chaining stopwatch/timer digits and driving 7-seg display logic. Replaces clocking logic directly off the divided clock with a clean clock-enable style.

Parameters:
WIDTH, 8, counter and modulus width in bits
SYNC_STAGES, 2, synchroniser depth for SlowClk (min 2)

Ports:
ClkIn  in  1  system clock; all state on posedge
RstN  in  1  asynchronous active-low reset
SlowClk  in  1  divided clock, asynchronous to ClkIn
Run  in  1  level; 1 = count ticks, 0 = hold count
Clear  in  1  synchronous one-cycle pulse; zeroes count
Modulus  in  WIDTH  count period; counter runs 0..Modulus-1
Tick  out  1  one-cycle strobe per SlowClk rising edge
Count  out  WIDTH  current count value
Wrap  out  1  one-cycle strobe when Count wraps to 0
Running  out  1  1 while FSM in RUNNING

Behaviour:
- Reset (RstN=0, async): sync chain, edge-history flop, Tick, Count, Wrap, Running all 0; FSM -> ARM.
- Synchroniser: SYNC_STAGES flops, then one history flop. Rise = last stage & ~history.
- Tick is registered. SlowClk rise sampled by stage 1 at ClkIn edge E0 -> Tick high for exactly one cycle after edge E(SYNC_STAGES). With the default, that is E2.
- FSM states:
  - ARM: entered on reset. Stays SYNC_STAGES+1 cycles to flush the chain. Rises are suppressed, so a high SlowClk at reset release never yields Tick. Exits to RUNNING if Run=1, else STOPPED.
  - STOPPED: Tick still generated. Count holds; Wrap=0. Run=1 -> RUNNING next cycle.
  - RUNNING: on a Tick cycle, Count updates on the same edge Tick asserts. Run=0 -> STOPPED next cycle. A tick coinciding with the Run 1->0 cycle still counts.
- Count arithmetic, applied on a Tick in RUNNING:
  - If Count >= Modulus-1: Count <= 0 and Wrap pulses.
  - Else: Count <= Count+1.
- Modulus special cases:
  - Modulus=0 means 2^WIDTH: natural wrap from all-ones to 0, with Wrap.
  - Modulus=1: Count stays 0; Wrap on every tick.
- Modulus lowered below the current Count: the next tick wraps to 0 with Wrap. There is no immediate correction.
- Clear (any state except ARM): Count <= 0, Wrap=0 that cycle. Clear has priority over a simultaneous tick; Tick itself still asserts.
- Clear during ARM: ignored; Count is already 0.
- Wrap is never asserted without Tick in the same cycle.
- Reset mid-operation: immediate return to reset values and ARM; no partial tick is emitted after release.
- Ticks arriving faster than 1 per SYNC_STAGES+1 ClkIn cycles are unsupported; SlowClk high and low phases must each be >= 2 ClkIn cycles.

Optional Feature:
Macro SLOW_TICK_STICKY_WRAP_EN.
- Defined: adds output WrapSticky (1 bit, reset 0). Set on any Wrap; cleared only by Clear or reset. Clear in the same cycle as Wrap leaves it 0, since Clear wins.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package: FSM state typedef (ARM, STOPPED, RUNNING; 2-bit encoding) and constant ARM_CYCLES = SYNC_STAGES+1.
- Natural sub-module: slow_edge_sync.
  - Parameterised SYNC_STAGES synchroniser, history flop, and rise output.
  - Has an enable input for the ARM mask; reused by other button/slow-signal inputs.
- Counter and FSM stay in the top module.

Test Plan:
- Reset release with SlowClk held high, Run=1 -> no Tick for 10 cycles; Running=1 from cycle 4; Count=0.
- WIDTH=8, Modulus=10, Run=1, SlowClk period 8 ClkIn cycles, 25 rises -> 25 Ticks, each 1 cycle wide, 2 cycles after the sampled edge. Wrap on rises 10 and 20; final Count=5.
- Modulus=0, Count preloaded to 255 via 255 ticks -> next tick gives Count=0 with Wrap=1. Modulus=1 -> Wrap on every Tick; Count stays 0.
- Run=0 at Count=3, 4 rises -> 4 Ticks, Count stays 3, Running=0. Run=1 again -> next tick gives Count=4.
- Clear asserted on the same cycle as a Tick at Count=9, Modulus=10 -> Count=0, Wrap=0, Tick=1. With SLOW_TICK_STICKY_WRAP_EN, WrapSticky stays 0.
- Modulus changed 10->4 while Count=7 -> next Tick gives Count=0 with Wrap. RstN pulsed low mid-count -> all outputs 0 asynchronously; FSM re-enters ARM.

Source files
------------

// File: rtl/slow_tick_counter_pkg.sv
// Shared FSM state type and timing constants for slow_tick_counter.
package slow_tick_counter_pkg;

  typedef enum logic [1:0] {
    ARM     = 2'b00,
    STOPPED = 2'b01,
    RUNNING = 2'b10
  } tickState_e;

  localparam int unsigned SYNC_STAGES_DEF = 32'd2;
  localparam int unsigned ARM_CYCLES      = SYNC_STAGES_DEF + 32'd1;

  // Cycles the FSM stays in ARM so the synchroniser chain and history flop are flushed.
  function automatic int unsigned armCycles(input int unsigned syncStages);
    return syncStages + 32'd1;
  endfunction

endpackage

// File: rtl/slow_edge_sync.sv
// Multi-stage synchroniser with a history flop producing a rising-edge indication.
// En masks the rise output, e.g. while the chain is still flushing after reset.
module slow_edge_sync #(
  parameter int unsigned SYNC_STAGES = 32'd2
) (
  input  logic ClkIn,
  input  logic RstN,
  input  logic AsyncIn,
  input  logic En,
  output logic Rise
);

  logic [SYNC_STAGES-1:0] syncChain_r;
  logic                   history_r;

  // Shift the asynchronous input through the chain; history trails the last stage.
  always_ff @(posedge ClkIn or negedge RstN) begin
    if (!RstN) begin
      syncChain_r <= {SYNC_STAGES{1'b0}};
      history_r   <= 1'b0;
    end else begin
      syncChain_r <= {syncChain_r[SYNC_STAGES-2:0], AsyncIn};
      history_r   <= syncChain_r[SYNC_STAGES-1];
    end
  end

  // Left combinational so the consumer registers it together with the state it updates.
  always_comb begin
    Rise = En & syncChain_r[SYNC_STAGES-1] & ~history_r;
  end

endmodule

// File: rtl/slow_tick_counter.sv
// Slow-clock tick generator and programmable modulo counter in the ClkIn domain.
// Optional macro SLOW_TICK_STICKY_WRAP_EN adds the WrapSticky output.
module slow_tick_counter
  import slow_tick_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 32'd8,
  parameter int unsigned SYNC_STAGES = 32'd2
) (
  input  logic             ClkIn,
  input  logic             RstN,
  input  logic             SlowClk,
  input  logic             Run,
  input  logic             Clear,
  input  logic [WIDTH-1:0] Modulus,
  output logic             Tick,
  output logic [WIDTH-1:0] Count,
  output logic             Wrap,
`ifdef SLOW_TICK_STICKY_WRAP_EN
  output logic             WrapSticky,
`endif
  output logic             Running
);

  localparam int unsigned ARM_LEN = armCycles(SYNC_STAGES);
  localparam int unsigned ACW     = (ARM_LEN > 32'd2) ? $clog2(ARM_LEN) : 32'd1;
  localparam logic [ACW-1:0] ARM_LAST = ACW'(ARM_LEN - 32'd1);

  tickState_e       state_r;
  logic [ACW-1:0]   armCnt_r;
  logic             tick_r;
  logic             wrap_r;
  logic             running_r;
  logic [WIDTH-1:0] count_r;

  logic             rise_s;
  logic             armed_s;
  logic             clearEff_s;
  logic             advance_s;
  logic             atLimit_s;
  logic             wrapSet_s;
  logic [WIDTH:0]   modExt_s;
  logic [WIDTH:0]   nextExt_s;

  assign armed_s = (state_r != ARM);

  slow_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) uEdgeSync (
    .ClkIn   (ClkIn),
    .RstN    (RstN),
    .AsyncIn (SlowClk),
    .En      (armed_s),
    .Rise    (rise_s)
  );

  // Modulus 0 stands for 2^WIDTH, so compare in WIDTH+1 bits; a count already past the
  // modulus (modulus lowered on the fly) also satisfies the limit and wraps next tick.
  always_comb begin
    modExt_s   = (Modulus == {WIDTH{1'b0}}) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, Modulus};
    nextExt_s  = {1'b0, count_r} + {{WIDTH{1'b0}}, 1'b1};
    atLimit_s  = (nextExt_s >= modExt_s);
    clearEff_s = Clear & armed_s;
    advance_s  = rise_s & (state_r == RUNNING) & ~clearEff_s;
    wrapSet_s  = advance_s & atLimit_s;
  end

  // FSM with registered Tick/Count/Wrap/Running; counting is decided by the pre-edge state.
  always_ff @(posedge ClkIn or negedge RstN) begin
    if (!RstN) begin
      state_r   <= ARM;
      armCnt_r  <= {ACW{1'b0}};
      tick_r    <= 1'b0;
      wrap_r    <= 1'b0;
      running_r <= 1'b0;
      count_r   <= {WIDTH{1'b0}};
    end else begin
      tick_r <= rise_s;
      wrap_r <= wrapSet_s;
      if (clearEff_s || wrapSet_s) begin
        count_r <= {WIDTH{1'b0}};
      end else if (advance_s) begin
        count_r <= nextExt_s[WIDTH-1:0];
      end else begin
        count_r <= count_r;
      end
      case (state_r)
        ARM: begin
          if (armCnt_r == ARM_LAST) begin
            armCnt_r <= {ACW{1'b0}};
            if (Run) begin
              state_r   <= RUNNING;
              running_r <= 1'b1;
            end else begin
              state_r   <= STOPPED;
              running_r <= 1'b0;
            end
          end else begin
            armCnt_r <= armCnt_r + ACW'(1);
          end
        end
        STOPPED: begin
          if (Run) begin
            state_r   <= RUNNING;
            running_r <= 1'b1;
          end else begin
            state_r   <= STOPPED;
            running_r <= 1'b0;
          end
        end
        RUNNING: begin
          if (!Run) begin
            state_r   <= STOPPED;
            running_r <= 1'b0;
          end else begin
            state_r   <= RUNNING;
            running_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ARM;
          armCnt_r  <= {ACW{1'b0}};
          running_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef SLOW_TICK_STICKY_WRAP_EN
  logic wrapSticky_r;

  // Remembers any wrap until cleared; Clear wins over a same-cycle wrap.
  always_ff @(posedge ClkIn or negedge RstN) begin
    if (!RstN) begin
      wrapSticky_r <= 1'b0;
    end else if (clearEff_s) begin
      wrapSticky_r <= 1'b0;
    end else if (wrapSet_s) begin
      wrapSticky_r <= 1'b1;
    end else begin
      wrapSticky_r <= wrapSticky_r;
    end
  end

  assign WrapSticky = wrapSticky_r;
`endif

  assign Tick    = tick_r;
  assign Count   = count_r;
  assign Wrap    = wrap_r;
  assign Running = running_r;

endmodule
